// File: rtl/sistemas_sincronos_mux_n_if.sv
// Bus bundle for sistemas_sincronos_mux_n: upstream sample offer plus the
// registered output with its valid/ready handshake.
// Optional feature macro: MUX_N_PARITY_EN adds o_parity to the bundle.
interface sistemas_sincronos_mux_n_if #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned W     = 1,
  parameter int unsigned SEL_W = 2
);

  logic [N_CH*W-1:0] i_data;
  logic [SEL_W-1:0]  i_selector;
  logic              i_mode;
  logic              i_valid;
  logic              o_ready;
  logic [W-1:0]      o_q;
  logic [SEL_W-1:0]  o_chan;
  logic              o_valid;
  logic              i_ready;
  logic              o_sel_err;
`ifdef MUX_N_PARITY_EN
  logic              o_parity;
`endif

  // Multiplexer side
  modport slave (
    input  i_data, i_selector, i_mode, i_valid, i_ready,
    output o_ready, o_q, o_chan, o_valid, o_sel_err
`ifdef MUX_N_PARITY_EN
    , output o_parity
`endif
  );

  // Source/consumer side
  modport master (
    output i_data, i_selector, i_mode, i_valid, i_ready,
    input  o_ready, o_q, o_chan, o_valid, o_sel_err
`ifdef MUX_N_PARITY_EN
    , input o_parity
`endif
  );

endinterface

// File: rtl/sistemas_sincronos_mux_n.sv
// Registered N-channel, W-bit multiplexer with valid/ready output handshake,
// round-robin auto-scan mode and out-of-range selector flagging.
// Optional feature macro: MUX_N_PARITY_EN (registered even parity of o_q).
// Interface parameters must match the module parameters.
module sistemas_sincronos_mux_n #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned W     = 1,
  parameter int unsigned SEL_W = 2
) (
  input logic i_clk,
  input logic i_rst,
  sistemas_sincronos_mux_n_if.slave bus
);

  localparam logic [31:0] N_CH_U   = 32'(N_CH);
  localparam logic [31:0] LAST_CH  = 32'(N_CH - 1);

  logic [W-1:0]     q;
  logic [SEL_W-1:0] chan;
  logic             valid;
  logic             sel_err;
  logic [SEL_W-1:0] scan;
`ifdef MUX_N_PARITY_EN
  logic             parity;
`endif

  logic             ready;
  logic             acc;
  logic [SEL_W-1:0] sel_eff;
  logic             sel_oor;
  logic [W-1:0]     ch_data;
  logic [SEL_W-1:0] scan_next;

  // Handshake, channel selection and scan-counter successor
  always_comb begin
    ready     = !valid || bus.i_ready;
    acc       = bus.i_valid && ready;
    sel_eff   = bus.i_mode ? scan : bus.i_selector;
    sel_oor   = 32'(sel_eff) >= N_CH_U;
    ch_data   = '0;
    for (int c = 0; c < int'(N_CH); c++) begin
      if (32'(sel_eff) == 32'(c)) begin
        ch_data = bus.i_data[c*W +: W];
      end
    end
    scan_next = (32'(scan) >= LAST_CH) ? '0 : scan + SEL_W'(1);
  end

  // Output register: load on accept, clear valid on drain, hold on stall
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      q       <= '0;
      chan    <= '0;
      valid   <= 1'b0;
      sel_err <= 1'b0;
`ifdef MUX_N_PARITY_EN
      parity  <= 1'b0;
`endif
    end else if (acc) begin
      q       <= sel_oor ? '0 : ch_data;
      chan    <= sel_eff;
      valid   <= 1'b1;
      sel_err <= !bus.i_mode && (32'(bus.i_selector) >= N_CH_U);
`ifdef MUX_N_PARITY_EN
      parity  <= sel_oor ? 1'b0 : ^ch_data;
`endif
    end else if (valid && bus.i_ready) begin
      valid   <= 1'b0;
    end
  end

  // Round-robin scan counter; only auto-mode accepts move it
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scan <= '0;
    end else if (acc && bus.i_mode) begin
      scan <= scan_next;
    end
  end

  assign bus.o_ready   = ready;
  assign bus.o_q       = q;
  assign bus.o_chan    = chan;
  assign bus.o_valid   = valid;
  assign bus.o_sel_err = sel_err;
`ifdef MUX_N_PARITY_EN
  assign bus.o_parity  = parity;
`endif

endmodule

// File: tb/tb_sistemas_sincronos_mux_n.sv
// Bench for sistemas_sincronos_mux_n: a 4-channel and a 3-channel instance
// (W=8, SEL_W=2) run in lockstep on shared stimulus, each with its own
// hand-written expectation queue drained by an independent monitor.
module tb_sistemas_sincronos_mux_n;

  typedef struct packed {
    logic [7:0] q;
    logic [1:0] chan;
    logic       err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data;
  logic [1:0]  sel;
  logic        mode;
  logic        valid;
  logic        ready;

  int checks = 0;
  int errors = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t na = '0;

  always #5 clk = ~clk;

  sistemas_sincronos_mux_n_if #(.N_CH(4), .W(8), .SEL_W(2)) ifa ();
  sistemas_sincronos_mux_n_if #(.N_CH(3), .W(8), .SEL_W(2)) ifb ();

  assign ifa.i_data     = data;
  assign ifa.i_selector = sel;
  assign ifa.i_mode     = mode;
  assign ifa.i_valid    = valid;
  assign ifa.i_ready    = ready;
  assign ifb.i_data     = data[23:0];
  assign ifb.i_selector = sel;
  assign ifb.i_mode     = mode;
  assign ifb.i_valid    = valid;
  assign ifb.i_ready    = ready;

  sistemas_sincronos_mux_n #(.N_CH(4), .W(8), .SEL_W(2)) dut_a (
    .i_clk(clk), .i_rst(rst), .bus(ifa)
  );
  sistemas_sincronos_mux_n #(.N_CH(3), .W(8), .SEL_W(2)) dut_b (
    .i_clk(clk), .i_rst(rst), .bus(ifb)
  );

  function automatic exp_t e(input logic [7:0] q, input logic [1:0] c, input logic err);
    exp_t r;
    r.q = q; r.chan = c; r.err = err;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // One cycle of stimulus; expectations are queued only when the sample is accepted
  task automatic step(input logic v, input logic r, input logic m, input logic [1:0] s,
                      input logic [31:0] d, input exp_t ea, input exp_t eb);
    valid = v; ready = r; mode = m; sel = s; data = d;
    #1;
    if (v && ifa.o_ready && !rst) qa.push_back(ea);
    if (v && ifb.o_ready && !rst) qb.push_back(eb);
    @(posedge clk);
    #1;
  endtask

  // Monitor for the 4-channel instance: compare each sample as it is consumed
  always @(negedge clk) begin
    if (!rst && ifa.o_valid && ready) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_sample", 32'(ifa.o_q), 32'hFFFF_FFFF);
      end else begin
        exp_t x;
        x = qa.pop_front();
        chk("a_q", 32'(ifa.o_q), 32'(x.q));
        chk("a_chan", 32'(ifa.o_chan), 32'(x.chan));
        chk("a_sel_err", 32'(ifa.o_sel_err), 32'(x.err));
`ifdef MUX_N_PARITY_EN
        chk("a_parity", 32'(ifa.o_parity), 32'(^x.q));
`endif
      end
    end
  end

  // Monitor for the 3-channel instance
  always @(negedge clk) begin
    if (!rst && ifb.o_valid && ready) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_sample", 32'(ifb.o_q), 32'hFFFF_FFFF);
      end else begin
        exp_t x;
        x = qb.pop_front();
        chk("b_q", 32'(ifb.o_q), 32'(x.q));
        chk("b_chan", 32'(ifb.o_chan), 32'(x.chan));
        chk("b_sel_err", 32'(ifb.o_sel_err), 32'(x.err));
`ifdef MUX_N_PARITY_EN
        chk("b_parity", 32'(ifb.o_parity), 32'(^x.q));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; valid = 1'b0; ready = 1'b1; mode = 1'b0; sel = 2'd0; data = '0;
    @(posedge clk); #1;
    step(0, 1, 0, 0, 0, na, na);
    step(0, 1, 0, 0, 0, na, na);
    rst = 1'b0;
    chk("rst_a_valid", 32'(ifa.o_valid), 0);
    chk("rst_a_q", 32'(ifa.o_q), 0);
    chk("rst_a_chan", 32'(ifa.o_chan), 0);
    chk("rst_b_sel_err", 32'(ifb.o_sel_err), 0);
    chk("rst_a_ready", 32'(ifa.o_ready), 1);

    // Manual sweep; selector 3 is out of range for the 3-channel instance
    step(1, 1, 0, 0, 32'h44332211, e(8'h11, 0, 0), e(8'h11, 0, 0));
    step(1, 1, 0, 1, 32'h44332211, e(8'h22, 1, 0), e(8'h22, 1, 0));
    chk("sweep_a_valid", 32'(ifa.o_valid), 1);
    step(1, 1, 0, 2, 32'h44332211, e(8'h33, 2, 0), e(8'h33, 2, 0));
    step(1, 1, 0, 3, 32'h44332211, e(8'h44, 3, 0), e(8'h00, 3, 1));
    step(1, 1, 0, 1, 32'h44332211, e(8'h22, 1, 0), e(8'h22, 1, 0));

    // Auto-scan: wrap at 4 for A, at 3 for B
    step(1, 1, 1, 0, 32'h44332211, e(8'h11, 0, 0), e(8'h11, 0, 0));
    step(1, 1, 1, 0, 32'h44332211, e(8'h22, 1, 0), e(8'h22, 1, 0));
    step(1, 1, 1, 0, 32'h44332211, e(8'h33, 2, 0), e(8'h33, 2, 0));
    step(1, 1, 1, 0, 32'h44332211, e(8'h44, 3, 0), e(8'h11, 0, 0));
    step(1, 1, 1, 0, 32'h44332211, e(8'h11, 0, 0), e(8'h22, 1, 0));
    // Manual accept holds the counter, then scan resumes
    step(1, 1, 0, 0, 32'h44332211, e(8'h11, 0, 0), e(8'h11, 0, 0));
    step(1, 1, 1, 3, 32'h44332211, e(8'h22, 1, 0), e(8'h33, 2, 0));

    // Backpressure: stall three cycles while data changes
    step(1, 1, 0, 1, 32'h44332211, e(8'h22, 1, 0), e(8'h22, 1, 0));
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 3, 32'hDEADBEEF ^ 32'(i), na, na);
      chk("stall_a_ready", 32'(ifa.o_ready), 0);
      chk("stall_b_ready", 32'(ifb.o_ready), 0);
      chk("stall_a_q", 32'(ifa.o_q), 32'h22);
      chk("stall_a_valid", 32'(ifa.o_valid), 1);
      chk("stall_b_chan", 32'(ifb.o_chan), 1);
    end
    // Release: old sample consumed and new one loaded on the same edge
    step(1, 1, 0, 2, 32'h55AA33CC, e(8'hAA, 2, 0), e(8'hAA, 2, 0));
    chk("release_a_valid", 32'(ifa.o_valid), 1);
    step(0, 1, 0, 0, 32'h55AA33CC, na, na);
    chk("drain_a_valid", 32'(ifa.o_valid), 0);
    chk("drain_b_q_hold", 32'(ifb.o_q), 32'hAA);

    // Reset while stalled with a pending sample
    step(1, 1, 1, 0, 32'h55AA33CC, e(8'hAA, 2, 0), e(8'hCC, 0, 0));
    step(0, 0, 0, 0, 32'h55AA33CC, na, na);
    rst = 1'b1;
    step(0, 0, 0, 0, 32'h55AA33CC, na, na);
    rst = 1'b0;
    qa.delete();
    qb.delete();
    chk("midrst_a_valid", 32'(ifa.o_valid), 0);
    chk("midrst_a_q", 32'(ifa.o_q), 0);
    chk("midrst_b_valid", 32'(ifb.o_valid), 0);
    chk("midrst_b_chan", 32'(ifb.o_chan), 0);
    // Scan counters restart at channel 0
    step(1, 1, 1, 3, 32'h44332211, e(8'h11, 0, 0), e(8'h11, 0, 0));

    // Parity patterns 0x07 and 0x03
    step(1, 1, 0, 0, 32'h00000307, e(8'h07, 0, 0), e(8'h07, 0, 0));
    step(1, 1, 0, 1, 32'h00000307, e(8'h03, 1, 0), e(8'h03, 1, 0));

    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, na, na);
    chk("end_a_queue_empty", 32'(qa.size()), 0);
    chk("end_b_queue_empty", 32'(qb.size()), 0);
    chk("end_a_valid", 32'(ifa.o_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
